axi4_lite_slave_decoder: RTL and testbench
==========================================

# axi4_lite_slave_decoder

AXI4-Lite slave endpoint that fans one AXI4-Lite port out to `NUM_PERIPH` simple request/done peripherals, each occupying an equal, contiguous address window. It is the multi-peripheral successor to the single-peripheral AXI4-Lite slave. It adds the following behaviour:
- address decode, with DECERR for unmapped addresses;
- a per-transaction timeout, with SLVERR;
- fully independent read and write paths.

It sits between the SoC interconnect and the peripheral register blocks.

## Interface
Parameters:
- `DATA_WIDTH`, 32: AXI data width; must be 32 or 64.
- `ADDRESS_WIDTH`, 32: AXI address width.
- `NUM_PERIPH`, 4: number of peripheral windows; range 1..16.
- `PERIPH_ADDR_BITS`, 12: each window is 2^PERIPH_ADDR_BITS bytes.
- `BASE_ADDR`, 0: start of window 0; must be aligned to 2^PERIPH_ADDR_BITS.
- `TIMEOUT_CYCLES`, 256: maximum number of cycles to wait for a peripheral's done; must be ≥ 2.

Ports (IDX = $clog2(NUM_PERIPH), minimum 1):
- `ACLK` in 1: the single clock.
- `ARESET` in 1: synchronous, active-high reset.
- `AWADDR`/`AWVALID`/`AWREADY`, `WDATA`/`WSTRB`/`WVALID`/`WREADY`, `BRESP`/`BVALID`/`BREADY`, `ARADDR`/`ARVALID`/`ARREADY`, `RDATA`/`RRESP`/`RVALID`/`RREADY`: standard AXI4-Lite slave directions and widths.
- `per_waddr` out PERIPH_ADDR_BITS: write offset within the selected window.
- `per_wdata` out DATA_WIDTH, `per_wstrb` out DATA_WIDTH/8: write data and strobes.
- `per_write_req` out NUM_PERIPH: one-hot, one-cycle write request.
- `per_write_done` in NUM_PERIPH: per-peripheral write completion.
- `per_bresp` in 2*NUM_PERIPH: peripheral i's write response is in bits [2i+1:2i].
- `per_raddr` out PERIPH_ADDR_BITS: read offset within the selected window.
- `per_read_req` out NUM_PERIPH: one-hot, one-cycle read request.
- `per_read_done` in NUM_PERIPH: per-peripheral read completion.
- `per_rdata` in DATA_WIDTH*NUM_PERIPH: peripheral i's read data is in slice i.
- `per_rresp` in 2*NUM_PERIPH: peripheral i's read response is in bits [2i+1:2i].

## Operation
- **Decode:** rel = ADDR[ADDRESS_WIDTH-1:PERIPH_ADDR_BITS] − BASE_ADDR[ADDRESS_WIDTH-1:PERIPH_ADDR_BITS].
  - The address is mapped iff ADDR ≥ BASE_ADDR and rel < NUM_PERIPH; the selected index is rel[IDX-1:0].
  - The peripheral offset is ADDR[PERIPH_ADDR_BITS-1:0].
- **Write FSM** (states W_IDLE, W_REQ, W_WAIT, W_RESP):
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle. Each is held once captured. When both are held, go to W_REQ if the address is mapped, otherwise to W_RESP with BRESP = DECERR.
  - W_REQ: `per_write_req[idx]` is high for exactly this cycle; the timeout counter is cleared. Go to W_WAIT.
  - W_WAIT: only `per_write_done[idx]` is sampled.
    - done → W_RESP with BRESP = `per_bresp[idx]`.
    - Counter reaches TIMEOUT_CYCLES−1 with no done → W_RESP with BRESP = SLVERR.
    - Done and timeout in the same cycle: done wins.
  - W_RESP: BVALID is high. On BVALID && BREADY, release the held AW/W and return to W_IDLE.
- **Read FSM** (states R_IDLE, R_REQ, R_WAIT, R_RESP): mirrors the write FSM, with one difference: a single AR handshake starts the transaction.
  - RDATA is captured from the selected slice on done.
  - On DECERR or SLVERR, RDATA = 0.
- Read and write paths are fully concurrent and may target the same peripheral. Ordering between the two paths is not guaranteed.
- Done pulses from non-selected peripherals, and a done arriving after a timeout, are ignored. Done pulses are never queued.
- The `per_*addr`, `per_wdata` and `per_wstrb` outputs hold their last captured values outside a transaction.

## Timing
- **While ARESET is high:** every output is 0, including AWREADY, WREADY and ARREADY. FSMs are in their IDLE states, hold flags are cleared, and counters are 0. Asserting ARESET mid-transaction aborts that transaction with no response.
- **Ready signals:**
  - AWREADY = !ARESET && W_IDLE && !aw_held.
  - WREADY = !ARESET && W_IDLE && !w_held.
  - ARREADY = !ARESET && R_IDLE.
  - All three are therefore high on the first cycle after reset release.
- **Mapped write, latency:** handshake completing at edge N → `per_write_req` high in cycle N+1. A done in cycle N+1+k (k ≥ 1) → BVALID in cycle N+2+k.
- **Unmapped write:** BVALID in cycle N+1.
- **Timeout:** BVALID or RVALID is asserted TIMEOUT_CYCLES+1 cycles after the request cycle.
- **Response hold:** BVALID/BRESP and RVALID/RDATA/RRESP stay stable until accepted.
- **Next transaction:** the earliest new AW/AR handshake is one cycle after the response handshake.

## Structure
- Package `axi4_lite_pkg`:
  - `resp_t` (OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11);
  - `wr_state_t`;
  - `rd_state_t`.
- Sub-module `axi4_lite_addr_decode`: combinational; address in → {mapped, idx, offset}. It is instantiated twice, once for the write path and once for the read path.

## Test plan
Default parameters are used throughout (BASE_ADDR = 0, NUM_PERIPH = 4, PERIPH_ADDR_BITS = 12).
1. Write to AWADDR = 0x2010, WDATA = 0xDEADBEEF, WSTRB = 0xF, with W presented 3 cycles before AW. Peripheral 2 asserts done after 2 cycles → `per_write_req` = 4'b0100, `per_waddr` = 0x010, BRESP = OKAY.
2. Read from ARADDR = 0x3004; peripheral 3 returns 0x12345678 with RRESP = OKAY. Hold RREADY low for 5 cycles → RVALID and RDATA stay stable, then complete.
3. Write to 0x4000 and read from 0x8000 (both unmapped) → no `per_*_req` pulses; BRESP = DECERR, RRESP = DECERR, RDATA = 0.
4. Write to peripheral 1, which never asserts done → BRESP = SLVERR exactly TIMEOUT_CYCLES+1 cycles after the request. A late done from peripheral 1 after this point is ignored.
5. Concurrent write to peripheral 0 and read from peripheral 0, with done asserted on both paths in the same cycle → both responses are OKAY and neither path stalls the other.
6. Assert ARESET while in W_WAIT → all outputs are 0 the next cycle, and AWREADY = 1 in the first cycle after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite multi-peripheral slave decoder.
//   resp_t     : AXI response encoding
//   wr_state_t : write-path FSM states
//   rd_state_t : read-path FSM states
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_WAIT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_slave_decoder_if.sv
// AXI4-Lite bus bundle.
//   slave  modport : used by the decoder (drives ready, B and R channels)
//   master modport : used by whoever drives requests (interconnect / bench)
interface axi4_lite_slave_decoder_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
);
  import axi4_lite_pkg::*;

  logic [ADDRESS_WIDTH-1:0]  AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  resp_t                     BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [ADDRESS_WIDTH-1:0]  ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  resp_t                     RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi4_lite_addr_decode.sv
// Combinational window decoder: maps a byte address onto one of NUM_PERIPH
// equal windows starting at BASE_ADDR.
//   addr_i   : AXI byte address
//   mapped_o : address falls inside one of the windows
//   idx_o    : selected window index (valid when mapped_o)
//   offset_o : byte offset within the window
module axi4_lite_addr_decode #(
  parameter int unsigned              ADDRESS_WIDTH    = 32,
  parameter int unsigned              NUM_PERIPH       = 4,
  parameter int unsigned              PERIPH_ADDR_BITS = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int unsigned              IdxW             = 2
) (
  input  logic [ADDRESS_WIDTH-1:0]    addr_i,
  output logic                        mapped_o,
  output logic [IdxW-1:0]             idx_o,
  output logic [PERIPH_ADDR_BITS-1:0] offset_o
);

  localparam int unsigned RelW = ADDRESS_WIDTH - PERIPH_ADDR_BITS;
  localparam logic [RelW-1:0] NumPeriph = RelW'(NUM_PERIPH);

  logic [RelW-1:0] rel;

  // Window number relative to window 0; wraps for addresses below BASE_ADDR,
  // which the explicit lower-bound compare rejects.
  assign rel      = addr_i[ADDRESS_WIDTH-1:PERIPH_ADDR_BITS]
                  - BASE_ADDR[ADDRESS_WIDTH-1:PERIPH_ADDR_BITS];
  assign mapped_o = (addr_i >= BASE_ADDR) && (rel < NumPeriph);
  assign idx_o    = rel[IdxW-1:0];
  assign offset_o = addr_i[PERIPH_ADDR_BITS-1:0];

endmodule

// File: rtl/axi4_lite_slave_decoder.sv
// AXI4-Lite slave that fans one port out to NUM_PERIPH request/done
// peripherals. Independent write and read FSMs, DECERR on unmapped
// addresses, SLVERR when a peripheral does not answer within TIMEOUT_CYCLES.
//   ACLK, ARESET   : clock, synchronous active-high reset
//   axi            : AXI4-Lite slave bundle
//   per_w*         : write offset/data/strobe, one-hot write request
//   per_write_done, per_bresp : per-peripheral write completion/response
//   per_raddr, per_read_req   : read offset, one-hot read request
//   per_read_done, per_rdata, per_rresp : per-peripheral read completion
module axi4_lite_slave_decoder
  import axi4_lite_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH       = 32,
  parameter int unsigned              ADDRESS_WIDTH    = 32,
  parameter int unsigned              NUM_PERIPH       = 4,
  parameter int unsigned              PERIPH_ADDR_BITS = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int unsigned              TIMEOUT_CYCLES   = 256
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  axi4_lite_slave_decoder_if.slave         axi,
  output logic [PERIPH_ADDR_BITS-1:0]      per_waddr,
  output logic [DATA_WIDTH-1:0]            per_wdata,
  output logic [DATA_WIDTH/8-1:0]          per_wstrb,
  output logic [NUM_PERIPH-1:0]            per_write_req,
  input  logic [NUM_PERIPH-1:0]            per_write_done,
  input  logic [2*NUM_PERIPH-1:0]          per_bresp,
  output logic [PERIPH_ADDR_BITS-1:0]      per_raddr,
  output logic [NUM_PERIPH-1:0]            per_read_req,
  input  logic [NUM_PERIPH-1:0]            per_read_done,
  input  logic [DATA_WIDTH*NUM_PERIPH-1:0] per_rdata,
  input  logic [2*NUM_PERIPH-1:0]          per_rresp
);

  localparam int unsigned IdxW  = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  // Per-peripheral slices unpacked once so selection is a plain array index.
  resp_t                 wresp_arr [NUM_PERIPH];
  resp_t                 rresp_arr [NUM_PERIPH];
  logic [DATA_WIDTH-1:0] rdata_arr [NUM_PERIPH];

  for (genvar g = 0; g < NUM_PERIPH; g++) begin : g_unpack
    assign wresp_arr[g] = resp_t'(per_bresp[2*g +: 2]);
    assign rresp_arr[g] = resp_t'(per_rresp[2*g +: 2]);
    assign rdata_arr[g] = per_rdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------- decode
  logic                        wdec_mapped, rdec_mapped;
  logic [IdxW-1:0]             wdec_idx, rdec_idx;
  logic [PERIPH_ADDR_BITS-1:0] wdec_offset, rdec_offset;

  axi4_lite_addr_decode #(
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .NUM_PERIPH      (NUM_PERIPH),
    .PERIPH_ADDR_BITS(PERIPH_ADDR_BITS),
    .BASE_ADDR       (BASE_ADDR),
    .IdxW            (IdxW)
  ) u_wdec (
    .addr_i  (axi.AWADDR),
    .mapped_o(wdec_mapped),
    .idx_o   (wdec_idx),
    .offset_o(wdec_offset)
  );

  axi4_lite_addr_decode #(
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .NUM_PERIPH      (NUM_PERIPH),
    .PERIPH_ADDR_BITS(PERIPH_ADDR_BITS),
    .BASE_ADDR       (BASE_ADDR),
    .IdxW            (IdxW)
  ) u_rdec (
    .addr_i  (axi.ARADDR),
    .mapped_o(rdec_mapped),
    .idx_o   (rdec_idx),
    .offset_o(rdec_offset)
  );

  // ------------------------------------------------------------ write path
  wr_state_t                   wr_state_q, wr_state_d;
  logic                        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [PERIPH_ADDR_BITS-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [StrbW-1:0]            wstrb_q;
  logic                        wmapped_q;
  logic [IdxW-1:0]             widx_q;
  logic [CntW-1:0]             wcnt_q, wcnt_d;
  resp_t                       bresp_q, bresp_d;
  logic                        awready, wready, aw_hs, w_hs;

  assign awready = !ARESET && (wr_state_q == W_IDLE) && !aw_held_q;
  assign wready  = !ARESET && (wr_state_q == W_IDLE) && !w_held_q;
  assign aw_hs   = axi.AWVALID && awready;
  assign w_hs    = axi.WVALID && wready;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    wcnt_d     = wcnt_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        // Launch on the edge that completes the second handshake; the decode
        // result comes live from AWADDR if AW is handshaking this cycle.
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (aw_hs ? wdec_mapped : wmapped_q) begin
            wr_state_d = W_REQ;
          end else begin
            wr_state_d = W_RESP;
            bresp_d    = DECERR;
          end
        end
      end
      W_REQ: begin
        wcnt_d     = '0;
        wr_state_d = W_WAIT;
      end
      W_WAIT: begin
        if (per_write_done[widx_q]) begin
          wr_state_d = W_RESP;
          bresp_d    = wresp_arr[widx_q];
        end else if (wcnt_q == CntLast) begin
          wr_state_d = W_RESP;
          bresp_d    = SLVERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      W_RESP: begin
        if (axi.BREADY) begin
          wr_state_d = W_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wmapped_q  <= 1'b0;
      widx_q     <= '0;
      wcnt_q     <= '0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      wcnt_q     <= wcnt_d;
      bresp_q    <= bresp_d;
      if (aw_hs) begin
        waddr_q   <= wdec_offset;
        wmapped_q <= wdec_mapped;
        widx_q    <= wdec_idx;
      end
      if (w_hs) begin
        wdata_q <= axi.WDATA;
        wstrb_q <= axi.WSTRB;
      end
    end
  end

  // ------------------------------------------------------------- read path
  rd_state_t                   rd_state_q, rd_state_d;
  logic [PERIPH_ADDR_BITS-1:0] raddr_q;
  logic [IdxW-1:0]             ridx_q;
  logic [CntW-1:0]             rcnt_q, rcnt_d;
  resp_t                       rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic                        arready, ar_hs;

  assign arready = !ARESET && (rd_state_q == R_IDLE);
  assign ar_hs   = axi.ARVALID && arready;

  always_comb begin
    rd_state_d = rd_state_q;
    rcnt_d     = rcnt_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (rdec_mapped) begin
            rd_state_d = R_REQ;
          end else begin
            rd_state_d = R_RESP;
            rresp_d    = DECERR;
            rdata_d    = '0;
          end
        end
      end
      R_REQ: begin
        rcnt_d     = '0;
        rd_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (per_read_done[ridx_q]) begin
          rd_state_d = R_RESP;
          rresp_d    = rresp_arr[ridx_q];
          rdata_d    = rdata_arr[ridx_q];
        end else if (rcnt_q == CntLast) begin
          rd_state_d = R_RESP;
          rresp_d    = SLVERR;
          rdata_d    = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      R_RESP: begin
        if (axi.RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      raddr_q    <= '0;
      ridx_q     <= '0;
      rcnt_q     <= '0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rcnt_q     <= rcnt_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      if (ar_hs) begin
        raddr_q <= rdec_offset;
        ridx_q  <= rdec_idx;
      end
    end
  end

  // --------------------------------------------------------------- outputs
  // Every output is forced low while ARESET is high, not just after the edge.
  assign axi.AWREADY   = awready;
  assign axi.WREADY    = wready;
  assign axi.BVALID    = !ARESET && (wr_state_q == W_RESP);
  assign axi.BRESP     = ARESET ? OKAY : bresp_q;
  assign axi.ARREADY   = arready;
  assign axi.RVALID    = !ARESET && (rd_state_q == R_RESP);
  assign axi.RRESP     = ARESET ? OKAY : rresp_q;
  assign axi.RDATA     = ARESET ? '0 : rdata_q;

  assign per_waddr     = ARESET ? '0 : waddr_q;
  assign per_wdata     = ARESET ? '0 : wdata_q;
  assign per_wstrb     = ARESET ? '0 : wstrb_q;
  assign per_raddr     = ARESET ? '0 : raddr_q;
  assign per_write_req = (!ARESET && (wr_state_q == W_REQ)) ? (NUM_PERIPH'(1) << widx_q) : '0;
  assign per_read_req  = (!ARESET && (rd_state_q == R_REQ)) ? (NUM_PERIPH'(1) << ridx_q) : '0;

endmodule

// File: tb/tb_axi4_lite_slave_decoder.sv
module tb_axi4_lite_slave_decoder;
  import axi4_lite_pkg::*;

  localparam int unsigned Timeout = 256;

  logic         ACLK;
  logic         ARESET;
  logic [11:0]  per_waddr, per_raddr;
  logic [31:0]  per_wdata;
  logic [3:0]   per_wstrb;
  logic [3:0]   per_write_req, per_read_req;
  logic [3:0]   per_write_done, per_read_done;
  logic [7:0]   per_bresp, per_rresp;
  logic [127:0] per_rdata;

  int n_vec;
  int n_err;

  // Scoreboard: expected B responses and expected {RRESP, RDATA}.
  resp_t       bq[$];
  logic [33:0] rq[$];

  axi4_lite_slave_decoder_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) axi ();

  axi4_lite_slave_decoder #(
    .DATA_WIDTH      (32),
    .ADDRESS_WIDTH   (32),
    .NUM_PERIPH      (4),
    .PERIPH_ADDR_BITS(12),
    .BASE_ADDR       (32'h0),
    .TIMEOUT_CYCLES  (Timeout)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .axi           (axi),
    .per_waddr     (per_waddr),
    .per_wdata     (per_wdata),
    .per_wstrb     (per_wstrb),
    .per_write_req (per_write_req),
    .per_write_done(per_write_done),
    .per_bresp     (per_bresp),
    .per_raddr     (per_raddr),
    .per_read_req  (per_read_req),
    .per_read_done (per_read_done),
    .per_rdata     (per_rdata),
    .per_rresp     (per_rresp)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Response monitor: a handshake seen at the falling edge completes on the
  // following rising edge, so each one is popped exactly once.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (axi.BVALID && axi.BREADY) begin
        n_vec++;
        if (bq.size() == 0) begin
          n_err++;
          $display("FAIL sb_b_unexpected: got BRESP=%0d, want no response", axi.BRESP);
        end else begin
          resp_t exp_b;
          exp_b = bq.pop_front();
          if (axi.BRESP !== exp_b) begin
            n_err++;
            $display("FAIL sb_bresp: got %0d, want %0d", axi.BRESP, exp_b);
          end
        end
      end
      if (axi.RVALID && axi.RREADY) begin
        n_vec++;
        if (rq.size() == 0) begin
          n_err++;
          $display("FAIL sb_r_unexpected: got RRESP=%0d RDATA=%h", axi.RRESP, axi.RDATA);
        end else begin
          logic [33:0] exp_r;
          exp_r = rq.pop_front();
          if ({axi.RRESP, axi.RDATA} !== exp_r) begin
            n_err++;
            $display("FAIL sb_r: got resp=%0d data=%h, want resp=%0d data=%h",
                     axi.RRESP, axi.RDATA, exp_r[33:32], exp_r[31:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({axi.AWREADY, axi.WREADY, axi.ARREADY} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ready: got %b, want 000", {axi.AWREADY, axi.WREADY, axi.ARREADY});
    end
    n_vec++;
    if ({axi.BVALID, axi.RVALID, per_write_req, per_read_req} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, want 0",
               {axi.BVALID, axi.RVALID, per_write_req, per_read_req});
    end
    ARESET = 1'b0;
    #1;
    n_vec++;
    if ({axi.AWREADY, axi.WREADY, axi.ARREADY} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b, want 111",
               {axi.AWREADY, axi.WREADY, axi.ARREADY});
    end
  endtask

  // W arrives three cycles ahead of AW; peripheral 2 answers with k = 2.
  task automatic test_write_basic();
    axi.WDATA = 32'hDEADBEEF; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
    tick();
    axi.WVALID = 1'b0;
    n_vec++;
    if ({axi.WREADY, axi.AWREADY} !== 2'b01) begin
      n_err++;
      $display("FAIL wr_w_held: got wready/awready=%b, want 01", {axi.WREADY, axi.AWREADY});
    end
    tick(); tick();
    axi.AWADDR = 32'h2010; axi.AWVALID = 1'b1;
    bq.push_back(OKAY);
    tick();
    axi.AWVALID = 1'b0;
    n_vec++;
    if (per_write_req !== 4'b0100 || per_waddr !== 12'h010) begin
      n_err++;
      $display("FAIL wr_req: got req=%b waddr=%h, want 0100 010", per_write_req, per_waddr);
    end
    n_vec++;
    if (per_wdata !== 32'hDEADBEEF || per_wstrb !== 4'hF) begin
      n_err++;
      $display("FAIL wr_data: got %h/%h, want deadbeef/f", per_wdata, per_wstrb);
    end
    tick();
    n_vec++;
    if (per_write_req !== 4'b0000) begin
      n_err++;
      $display("FAIL wr_req_pulse: got %b, want 0000", per_write_req);
    end
    tick();
    per_write_done = 4'b0100;
    n_vec++;
    if (axi.BVALID !== 1'b0) begin
      n_err++;
      $display("FAIL wr_bvalid_early: got %b, want 0", axi.BVALID);
    end
    tick();
    per_write_done = 4'b0000;
    n_vec++;
    if (axi.BVALID !== 1'b1 || axi.BRESP !== OKAY) begin
      n_err++;
      $display("FAIL wr_bresp: got valid=%b resp=%0d, want 1 0", axi.BVALID, axi.BRESP);
    end
    axi.BREADY = 1'b1;
    tick();
    axi.BREADY = 1'b0;
    n_vec++;
    if (axi.BVALID !== 1'b0 || axi.AWREADY !== 1'b1) begin
      n_err++;
      $display("FAIL wr_release: got bvalid=%b awready=%b, want 0 1", axi.BVALID, axi.AWREADY);
    end
  endtask

  task automatic test_read_hold();
    per_rdata[96 +: 32] = 32'h12345678;
    per_rresp[7:6] = 2'b00;
    axi.ARADDR = 32'h3004; axi.ARVALID = 1'b1;
    rq.push_back({OKAY, 32'h12345678});
    tick();
    axi.ARVALID = 1'b0;
    n_vec++;
    if (per_read_req !== 4'b1000 || per_raddr !== 12'h004 || axi.ARREADY !== 1'b0) begin
      n_err++;
      $display("FAIL rd_req: got req=%b raddr=%h arready=%b, want 1000 004 0",
               per_read_req, per_raddr, axi.ARREADY);
    end
    tick();
    per_read_done = 4'b1000;
    tick();
    per_read_done = 4'b0000;
    per_rdata[96 +: 32] = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'h12345678 || axi.RRESP !== OKAY) begin
        n_err++;
        $display("FAIL rd_hold[%0d]: got valid=%b data=%h resp=%0d, want 1 12345678 0",
                 i, axi.RVALID, axi.RDATA, axi.RRESP);
      end
      tick();
    end
    axi.RREADY = 1'b1;
    tick();
    axi.RREADY = 1'b0;
    n_vec++;
    if (axi.RVALID !== 1'b0) begin
      n_err++;
      $display("FAIL rd_release: got %b, want 0", axi.RVALID);
    end
  endtask

  task automatic test_unmapped();
    axi.AWADDR = 32'h4000; axi.AWVALID = 1'b1;
    axi.WDATA = 32'h1; axi.WSTRB = 4'h1; axi.WVALID = 1'b1;
    axi.ARADDR = 32'h8000; axi.ARVALID = 1'b1;
    bq.push_back(DECERR);
    rq.push_back({DECERR, 32'h0});
    tick();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
    n_vec++;
    if (per_write_req !== 4'b0000 || per_read_req !== 4'b0000) begin
      n_err++;
      $display("FAIL unm_req: got w=%b r=%b, want 0000 0000", per_write_req, per_read_req);
    end
    n_vec++;
    if (axi.BVALID !== 1'b1 || axi.BRESP !== DECERR) begin
      n_err++;
      $display("FAIL unm_b: got valid=%b resp=%0d, want 1 3", axi.BVALID, axi.BRESP);
    end
    n_vec++;
    if (axi.RVALID !== 1'b1 || axi.RRESP !== DECERR || axi.RDATA !== 32'h0) begin
      n_err++;
      $display("FAIL unm_r: got valid=%b resp=%0d data=%h, want 1 3 0",
               axi.RVALID, axi.RRESP, axi.RDATA);
    end
    axi.BREADY = 1'b1; axi.RREADY = 1'b1;
    tick();
    axi.BREADY = 1'b0; axi.RREADY = 1'b0;
  endtask

  // Peripheral 1 never answers; stray dones from other peripherals and a late
  // done from peripheral 1 must all be ignored.
  task automatic test_timeout();
    int cycles;
    axi.AWADDR = 32'h1000; axi.AWVALID = 1'b1;
    axi.WDATA = 32'h55; axi.WSTRB = 4'h3; axi.WVALID = 1'b1;
    bq.push_back(SLVERR);
    tick();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
    n_vec++;
    if (per_write_req !== 4'b0010) begin
      n_err++;
      $display("FAIL to_req: got %b, want 0010", per_write_req);
    end
    cycles = 0;
    while (axi.BVALID !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
      if (cycles == 1) per_write_done = 4'b1101;
      else if (cycles == 2) per_write_done = 4'b0000;
    end
    n_vec++;
    if (cycles != Timeout + 1) begin
      n_err++;
      $display("FAIL to_latency: got %0d cycles, want %0d", cycles, Timeout + 1);
    end
    per_write_done = 4'b0010;
    per_bresp[3:2] = 2'b00;
    tick();
    per_write_done = 4'b0000;
    n_vec++;
    if (axi.BVALID !== 1'b1 || axi.BRESP !== SLVERR) begin
      n_err++;
      $display("FAIL to_bresp: got valid=%b resp=%0d, want 1 2", axi.BVALID, axi.BRESP);
    end
    axi.BREADY = 1'b1;
    tick();
    axi.BREADY = 1'b0;
    per_write_done = 4'b0010;
    tick();
    per_write_done = 4'b0000;
    tick();
    n_vec++;
    if (axi.BVALID !== 1'b0) begin
      n_err++;
      $display("FAIL to_late_done: got bvalid=%b, want 0", axi.BVALID);
    end
  endtask

  task automatic test_read_timeout();
    int cycles;
    per_rdata[32 +: 32] = 32'hA5A5A5A5;
    axi.ARADDR = 32'h1008; axi.ARVALID = 1'b1;
    rq.push_back({SLVERR, 32'h0});
    tick();
    axi.ARVALID = 1'b0;
    cycles = 0;
    while (axi.RVALID !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
    end
    n_vec++;
    if (cycles != Timeout + 1 || axi.RDATA !== 32'h0 || axi.RRESP !== SLVERR) begin
      n_err++;
      $display("FAIL rto: got cycles=%0d data=%h resp=%0d, want %0d 0 2",
               cycles, axi.RDATA, axi.RRESP, Timeout + 1);
    end
    axi.RREADY = 1'b1;
    tick();
    axi.RREADY = 1'b0;
  endtask

  task automatic test_concurrent();
    per_bresp[1:0] = 2'b00;
    per_rresp[1:0] = 2'b00;
    per_rdata[0 +: 32] = 32'hCAFEF00D;
    axi.AWADDR = 32'h0040; axi.AWVALID = 1'b1;
    axi.WDATA = 32'h0BADF00D; axi.WSTRB = 4'hC; axi.WVALID = 1'b1;
    axi.ARADDR = 32'h0080; axi.ARVALID = 1'b1;
    bq.push_back(OKAY);
    rq.push_back({OKAY, 32'hCAFEF00D});
    tick();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
    n_vec++;
    if (per_write_req !== 4'b0001 || per_read_req !== 4'b0001) begin
      n_err++;
      $display("FAIL cc_req: got w=%b r=%b, want 0001 0001", per_write_req, per_read_req);
    end
    n_vec++;
    if (per_waddr !== 12'h040 || per_raddr !== 12'h080 || per_wdata !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL cc_addr: got %h %h %h, want 040 080 0badf00d",
               per_waddr, per_raddr, per_wdata);
    end
    tick();
    per_write_done = 4'b0001; per_read_done = 4'b0001;
    tick();
    per_write_done = 4'b0000; per_read_done = 4'b0000;
    n_vec++;
    if ({axi.BVALID, axi.RVALID} !== 2'b11 || axi.BRESP !== OKAY || axi.RDATA !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL cc_resp: got bv/rv=%b bresp=%0d rdata=%h, want 11 0 cafef00d",
               {axi.BVALID, axi.RVALID}, axi.BRESP, axi.RDATA);
    end
    axi.BREADY = 1'b1; axi.RREADY = 1'b1;
    tick();
    axi.BREADY = 1'b0; axi.RREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    axi.AWADDR = 32'h0004; axi.AWVALID = 1'b1;
    axi.WDATA = 32'h77; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
    axi.ARADDR = 32'h2008; axi.ARVALID = 1'b1;
    tick();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
    tick();
    ARESET = 1'b1;
    tick();
    n_vec++;
    if ({axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID, axi.BRESP, axi.RRESP,
         axi.RDATA, per_write_req, per_read_req, per_waddr, per_raddr, per_wdata,
         per_wstrb} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got nonzero output(s) waddr=%h wdata=%h raddr=%h, want all 0",
               per_waddr, per_wdata, per_raddr);
    end
    ARESET = 1'b0;
    #1;
    n_vec++;
    if (axi.AWREADY !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_awready: got %b, want 1", axi.AWREADY);
    end
    axi.BREADY = 1'b1; axi.RREADY = 1'b1;
    repeat (3) tick();
    axi.BREADY = 1'b0; axi.RREADY = 1'b0;
    n_vec++;
    if ({axi.BVALID, axi.RVALID} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_noresp: got %b, want 00", {axi.BVALID, axi.RVALID});
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ARESET = 1'b1;
    axi.AWADDR = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 1'b0;
    axi.BREADY = 1'b0;
    axi.ARADDR = '0; axi.ARVALID = 1'b0;
    axi.RREADY = 1'b0;
    per_write_done = '0; per_read_done = '0;
    per_bresp = '0; per_rresp = '0; per_rdata = '0;

    test_reset();
    test_write_basic();
    test_read_hold();
    test_unmapped();
    test_timeout();
    test_read_timeout();
    test_concurrent();
    test_reset_mid();

    tick();
    n_vec++;
    if (bq.size() != 0 || rq.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d B and %0d R pending, want 0 0", bq.size(), rq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
